// File: rtl/bias_add_1.sv
// bias_add_1: loads KERN bias words per frame, then adds them channel by
// channel to the layer-1 accumulator stream with signed saturation.
module bias_add_1 #(
    parameter int KERN = 16,
    parameter int NPIX = 576,
    parameter int DW   = 16
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic [DW-1:0] bias_V_dout,
    input  logic          bias_V_empty_n,
    output logic          bias_V_read,
    input  logic [DW-1:0] input_V_dout,
    input  logic          input_V_empty_n,
    output logic          input_V_read,
    output logic [DW-1:0] output_V_din,
    input  logic          output_V_full_n,
    output logic          output_V_write
);

    localparam int CW = (KERN > 1) ? $clog2(KERN) : 1;
    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic {LOAD, RUN} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] bias_mem [KERN];
    logic [CW-1:0] ch;
    logic [PW-1:0] pix;
    logic          out_valid;
    logic [DW-1:0] out_reg;
    logic          adv, b_rd, i_rd, ch_last, pix_last;
    logic [DW:0]   sum;
    logic [DW-1:0] sat;

    // Datapath: sign-extended add with clamp to the DW-bit signed range
    always_comb begin
        adv      = !out_valid | output_V_full_n;
        ch_last  = (ch == CW'(KERN - 1));
        pix_last = (pix == PW'(NPIX - 1));
        sum      = {bias_mem[ch][DW-1], bias_mem[ch]} + {input_V_dout[DW-1], input_V_dout};
        if (sum[DW] != sum[DW-1])
            sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat = sum[DW-1:0];
    end

    // FSM next state and read strobes; reads are held low while reset is asserted
    always_comb begin
        state_nx = state;
        b_rd     = 1'b0;
        i_rd     = 1'b0;
        case (state)
            LOAD: begin
                b_rd = bias_V_empty_n & ap_rst_n;
                if (b_rd && ch_last)
                    state_nx = RUN;
            end
            RUN: begin
                i_rd = input_V_empty_n & adv & ap_rst_n;
                if (i_rd && ch_last && pix_last)
                    state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            state <= LOAD;
        else
            state <= state_nx;
    end

    // Channel and pixel counters; ch is shared by LOAD and RUN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ch  <= '0;
            pix <= '0;
        end else if (b_rd || i_rd) begin
            ch <= ch_last ? '0 : ch + CW'(1);
            if (i_rd && ch_last)
                pix <= pix_last ? '0 : pix + PW'(1);
        end
    end

    // Bias register file; contents are don't-care after reset
    always_ff @(posedge ap_clk) begin
        if (b_rd)
            bias_mem[ch] <= bias_V_dout;
    end

    // Output stage drains independently of the FSM state
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            out_reg   <= '0;
        end else if (i_rd) begin
            out_valid <= 1'b1;
            out_reg   <= sat;
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end

    assign bias_V_read    = b_rd;
    assign input_V_read   = i_rd;
    assign output_V_write = out_valid & output_V_full_n;
    assign output_V_din   = out_reg;

endmodule

// File: tb/tb_bias_add_1.sv
// Randomized self-checking bench for bias_add_1 with a queue-based FIFO and
// arithmetic reference model.
module tb_bias_add_1;

    localparam int K = 4;
    localparam int N = 2;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [15:0] bias_V_dout;
    logic        bias_V_empty_n;
    logic        bias_V_read;
    logic [15:0] input_V_dout;
    logic        input_V_empty_n;
    logic        input_V_read;
    logic [15:0] output_V_din;
    logic        output_V_full_n;
    logic        output_V_write;

    bias_add_1 #(.KERN(K), .NPIX(N), .DW(16)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .bias_V_dout     (bias_V_dout),
        .bias_V_empty_n  (bias_V_empty_n),
        .bias_V_read     (bias_V_read),
        .input_V_dout    (input_V_dout),
        .input_V_empty_n (input_V_empty_n),
        .input_V_read    (input_V_read),
        .output_V_din    (output_V_din),
        .output_V_full_n (output_V_full_n),
        .output_V_write  (output_V_write)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    int bq[$];
    int iq[$];
    int exp_q[$];

    int pb, pi, po;
    bit force_full;
    bit need_load;
    bit last_ird;
    int bias_since;
    int in_cnt;
    int wr_cnt;

    int b_a[K];
    int x_a[K*N];

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic push_frame(input int b[K], input int x[K*N]);
        for (int i = 0; i < K; i++) bq.push_back(b[i]);
        for (int i = 0; i < K*N; i++) begin
            iq.push_back(x[i]);
            exp_q.push_back(sat16(x[i] + b[i % K]));
        end
    endtask

    task automatic drive();
        bias_V_empty_n  = (bq.size() > 0) && (int'($urandom_range(99)) >= pb);
        bias_V_dout     = (bq.size() > 0) ? 16'(bq[0]) : '0;
        input_V_empty_n = (iq.size() > 0) && (int'($urandom_range(99)) >= pi);
        input_V_dout    = (iq.size() > 0) ? 16'(iq[0]) : '0;
        output_V_full_n = force_full ? 1'b0 : (int'($urandom_range(99)) >= po);
    endtask

    task automatic sample();
        check("brd_empty", int'(bias_V_read & ~bias_V_empty_n), 0);
        check("ird_empty", int'(input_V_read & ~input_V_empty_n), 0);
        check("wr_full", int'(output_V_write & ~output_V_full_n), 0);
        last_ird = input_V_read;
        if (bias_V_read) begin
            if (bq.size() > 0) void'(bq.pop_front());
            bias_since++;
        end
        if (input_V_read) begin
            check("rd_overlap", int'(bias_V_read), 0);
            if (need_load) begin
                check("load_len", bias_since, K);
                need_load = 1'b0;
            end else begin
                check("midframe_bias", bias_since, 0);
            end
            bias_since = 0;
            if (iq.size() > 0) void'(iq.pop_front());
            in_cnt++;
            if (in_cnt == K*N) begin
                in_cnt    = 0;
                need_load = 1'b1;
            end
        end
        if (output_V_write) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("extra_wr", 1, 0);
            else check("out", int'($signed(output_V_din)), exp_q.pop_front());
        end
    endtask

    // Called at a falling edge; samples 1 time unit before the rising edge
    task automatic cycle();
        drive();
        #4;
        sample();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || bq.size() > 0 || iq.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check("timeout", 0, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_brd"}, int'(bias_V_read), 0);
        check({tag, "_ird"}, int'(input_V_read), 0);
        check({tag, "_wr"}, int'(output_V_write), 0);
        check({tag, "_din"}, int'(output_V_din), 0);
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        pb = 0; pi = 0; po = 0;
        force_full = 1'b0;
        need_load  = 1'b1;
        last_ird   = 1'b0;
        bias_since = 0;
        in_cnt     = 0;
        wr_cnt     = 0;

        // Reset state with a non-empty bias FIFO in front of the block
        b_a = '{1, -2, 3, -4};
        for (int i = 0; i < K*N; i++) x_a[i] = 10 + i;
        push_frame(b_a, x_a);
        drive();
        #1;
        check_outputs_zero("rst");
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Basic frame, no bubbles
        run_drain(200);
        check("basic_wr", wr_cnt, K*N);

        // Saturation at both rails plus exact cancellation
        b_a = '{32000, -32000, 100, 0};
        x_a = '{1000, -1000, -100, 7, -5, 3, 32767, -32768};
        push_frame(b_a, x_a);
        run_drain(200);

        // Backpressure: hold full_n low for 5 cycles with a word pending
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < K; i++) b_a[i] = rnd16();
            for (int i = 0; i < K*N; i++) x_a[i] = rnd16();
            push_frame(b_a, x_a);
        end
        begin
            int n = 0;
            int w0 = wr_cnt;
            while (!(last_ird && wr_cnt >= w0 + 2) && n < 100) begin
                cycle();
                n++;
            end
            if (n >= 100) check("bp_timeout", 0, 1);
        end
        force_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive();
            #4;
            check("bp_wr", int'(output_V_write), 0);
            check("bp_ird", int'(input_V_read), 0);
            if (exp_q.size() > 0) check("bp_hold", int'($signed(output_V_din)), exp_q[0]);
            else check("bp_noexp", 0, 1);
            sample();
            @(posedge ap_clk);
            @(negedge ap_clk);
        end
        force_full = 1'b0;
        run_drain(300);

        // Back-to-back frames, second with new biases
        for (int i = 0; i < K*N; i++) x_a[i] = rnd16();
        for (int i = 0; i < K; i++) b_a[i] = rnd16();
        push_frame(b_a, x_a);
        b_a = '{100, 200, 300, 400};
        for (int i = 0; i < K*N; i++) x_a[i] = int'($urandom_range(2000)) - 1000;
        push_frame(b_a, x_a);
        run_drain(300);

        // Random bubbles on all three FIFO handshakes
        pb = 30; pi = 30; po = 30;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < K; i++) b_a[i] = rnd16();
            for (int i = 0; i < K*N; i++) x_a[i] = rnd16();
            push_frame(b_a, x_a);
        end
        run_drain(2000);
        pb = 0; pi = 0; po = 0;

        // Reset after 3 outputs of a frame
        for (int i = 0; i < K; i++) b_a[i] = rnd16();
        for (int i = 0; i < K*N; i++) x_a[i] = rnd16();
        push_frame(b_a, x_a);
        begin
            int n = 0;
            int w0 = wr_cnt;
            while (wr_cnt < w0 + 3 && n < 100) begin
                cycle();
                n++;
            end
            if (n >= 100) check("mid_timeout", 0, 1);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        bq.delete();
        iq.delete();
        exp_q.delete();
        need_load  = 1'b1;
        bias_since = 0;
        in_cnt     = 0;
        for (int i = 0; i < K; i++) b_a[i] = rnd16();
        for (int i = 0; i < K*N; i++) x_a[i] = rnd16();
        push_frame(b_a, x_a);
        drive();
        #1;
        check_outputs_zero("midrst_hold");
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
